// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing front end for a 32-bit combinational ALU.
// Commands enter a 4-deep FIFO through a valid/ready port, are issued one at
// a time onto registered ALU operands, and the ALU result and flags are
// captured one cycle later and offered on a valid/ready result port.
//
// Optional build macro: ALU_CTRL_CHAIN_EN
//   When defined, a command with chain=1 takes its A operand from the most
//   recently captured result instead of its own A field.
module alu_ctrl (
    input  logic        ALU_CTRL_clk_xi,
    input  logic        ALU_CTRL_rst_xi,
    input  logic        ALU_CTRL_cmd_valid_xi,
    output logic        ALU_CTRL_cmd_ready_xo,
    input  logic [31:0] ALU_CTRL_cmd_a_xi,
    input  logic [31:0] ALU_CTRL_cmd_b_xi,
    input  logic [2:0]  ALU_CTRL_cmd_op_xi,
    input  logic        ALU_CTRL_cmd_chain_xi,
    output logic [31:0] ALU_CTRL_alu_a_xo,
    output logic [31:0] ALU_CTRL_alu_b_xo,
    output logic [2:0]  ALU_CTRL_alu_op_xo,
    input  logic [31:0] ALU_CTRL_alu_f_xi,
    input  logic        ALU_CTRL_alu_ovf_xi,
    input  logic        ALU_CTRL_alu_zero_xi,
    output logic        ALU_CTRL_res_valid_xo,
    input  logic        ALU_CTRL_res_ready_xi,
    output logic [31:0] ALU_CTRL_res_f_xo,
    output logic        ALU_CTRL_res_ovf_xo,
    output logic        ALU_CTRL_res_zero_xo,
    output logic        ALU_CTRL_busy_xo
);

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef struct packed {
        logic              chain;
        logic [2:0]        op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } cmd_t;

    // Only add and subtract produce a meaningful carry/borrow; any flag the
    // ALU raises for the logic, compare or shift ops is suppressed.
    function automatic logic qualify_ovf(input logic [2:0] op, input logic ovf);
        return ((op == OP_ADD) || (op == OP_SUB)) ? ovf : 1'b0;
    endfunction

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    cmd_t              fifo_mem [DEPTH];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    cmd_t              cmd_in;
    cmd_t              head;
    logic [DATA_W-1:0] head_a_sel;

    // Issue stage: operands held in front of the ALU.
    logic [DATA_W-1:0] opnd_a_p0;
    logic [DATA_W-1:0] opnd_b_p0;
    logic [2:0]        opnd_op_p0;

    // Result stage: captured ALU outputs.
    logic [DATA_W-1:0] res_f_p1;
    logic              res_ovf_p1;
    logic              res_zero_p1;
    logic              vld_p1;

    logic              res_take;

    assign fifo_empty = (count == 3'd0);
    assign fifo_full  = (count == 3'd4);

    // Held low during reset so nothing can be pushed into a FIFO being cleared.
    assign ALU_CTRL_cmd_ready_xo = !fifo_full && !ALU_CTRL_rst_xi;
    assign push = ALU_CTRL_cmd_valid_xi && ALU_CTRL_cmd_ready_xo;

    assign cmd_in = '{chain: ALU_CTRL_cmd_chain_xi,
                      op:    ALU_CTRL_cmd_op_xi,
                      b:     ALU_CTRL_cmd_b_xi,
                      a:     ALU_CTRL_cmd_a_xi};
    assign head = fifo_mem[rd_ptr];

    assign res_take = vld_p1 && ALU_CTRL_res_ready_xi;

    // Decide when the head of the FIFO moves into the operand registers.
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE: pop = !fifo_empty;
            ST_DONE: pop = res_take && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    // Next-state logic: IDLE waits for work, EXEC lasts exactly one cycle,
    // DONE waits for the consumer and chains straight into the next command.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (res_take) state_nxt = fifo_empty ? ST_IDLE : ST_EXEC;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge ALU_CTRL_clk_xi or posedge ALU_CTRL_rst_xi) begin
        if (ALU_CTRL_rst_xi) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are cleared.
    always_ff @(posedge ALU_CTRL_clk_xi) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge ALU_CTRL_clk_xi or posedge ALU_CTRL_rst_xi) begin
        if (ALU_CTRL_rst_xi) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_CTRL_CHAIN_EN
    logic [DATA_W-1:0] last_f;

    // Most recent captured result, feeding chained commands.
    always_ff @(posedge ALU_CTRL_clk_xi or posedge ALU_CTRL_rst_xi) begin
        if (ALU_CTRL_rst_xi) begin
            last_f <= '0;
        end else if (state == ST_EXEC) begin
            last_f <= ALU_CTRL_alu_f_xi;
        end
    end

    assign head_a_sel = head.chain ? last_f : head.a;
`else
    logic unused_chain;

    assign unused_chain = head.chain;
    assign head_a_sel   = head.a;
`endif

    // ---- stage p0: FIFO head -> ALU operand registers ----
    // Operands are only rewritten on a pop and otherwise keep their value.
    always_ff @(posedge ALU_CTRL_clk_xi or posedge ALU_CTRL_rst_xi) begin
        if (ALU_CTRL_rst_xi) begin
            opnd_a_p0  <= '0;
            opnd_b_p0  <= '0;
            opnd_op_p0 <= '0;
        end else if (pop) begin
            opnd_a_p0  <= head_a_sel;
            opnd_b_p0  <= head.b;
            opnd_op_p0 <= head.op;
        end
    end

    // ---- stage p1: ALU outputs -> result registers ----
    // Capture once per command in EXEC; hold until the consumer takes it.
    always_ff @(posedge ALU_CTRL_clk_xi or posedge ALU_CTRL_rst_xi) begin
        if (ALU_CTRL_rst_xi) begin
            res_f_p1    <= '0;
            res_ovf_p1  <= 1'b0;
            res_zero_p1 <= 1'b0;
            vld_p1      <= 1'b0;
        end else if (state == ST_EXEC) begin
            res_f_p1    <= ALU_CTRL_alu_f_xi;
            res_zero_p1 <= ALU_CTRL_alu_zero_xi;
            res_ovf_p1  <= qualify_ovf(opnd_op_p0, ALU_CTRL_alu_ovf_xi);
            vld_p1      <= 1'b1;
        end else if ((state == ST_DONE) && res_take) begin
            vld_p1      <= 1'b0;
        end
    end

    assign ALU_CTRL_alu_a_xo     = opnd_a_p0;
    assign ALU_CTRL_alu_b_xo     = opnd_b_p0;
    assign ALU_CTRL_alu_op_xo    = opnd_op_p0;

    assign ALU_CTRL_res_valid_xo = vld_p1;
    assign ALU_CTRL_res_f_xo     = res_f_p1;
    assign ALU_CTRL_res_ovf_xo   = res_ovf_p1;
    assign ALU_CTRL_res_zero_xo  = res_zero_p1;

    assign ALU_CTRL_busy_xo      = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with an attached behavioural ALU and a
// scoreboard fed at command acceptance and drained at result handshake.
module tb_alu_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic        cmd_chain;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_f;
    logic        alu_ovf;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_f;
    logic        res_ovf;
    logic        res_zero;
    logic        busy;

    logic        force_ovf;
    logic [32:0] alu_r;

    int          vectors;
    int          miscompares;
    int          cyc;

    logic [33:0] exp_q [$];
    int          hs_q  [$];
    logic [31:0] got_q [$];
    logic [31:0] model_last;

    logic [33:0] mon_e;
    logic [32:0] tap_r;
    logic [31:0] tap_a;
    logic        tap_ovf;

    alu_ctrl dut (
        .ALU_CTRL_clk_xi       (clk),
        .ALU_CTRL_rst_xi       (rst),
        .ALU_CTRL_cmd_valid_xi (cmd_valid),
        .ALU_CTRL_cmd_ready_xo (cmd_ready),
        .ALU_CTRL_cmd_a_xi     (cmd_a),
        .ALU_CTRL_cmd_b_xi     (cmd_b),
        .ALU_CTRL_cmd_op_xi    (cmd_op),
        .ALU_CTRL_cmd_chain_xi (cmd_chain),
        .ALU_CTRL_alu_a_xo     (alu_a),
        .ALU_CTRL_alu_b_xo     (alu_b),
        .ALU_CTRL_alu_op_xo    (alu_op),
        .ALU_CTRL_alu_f_xi     (alu_f),
        .ALU_CTRL_alu_ovf_xi   (alu_ovf),
        .ALU_CTRL_alu_zero_xi  (alu_zero),
        .ALU_CTRL_res_valid_xo (res_valid),
        .ALU_CTRL_res_ready_xi (res_ready),
        .ALU_CTRL_res_f_xo     (res_f),
        .ALU_CTRL_res_ovf_xo   (res_ovf),
        .ALU_CTRL_res_zero_xo  (res_zero),
        .ALU_CTRL_busy_xo      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // {carry/borrow, f} of the ALU operation table.
    function automatic logic [32:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [32:0] r;
        r = '0;
        case (op)
            3'd0: r = {1'b0, a & b};
            3'd1: r = {1'b0, a | b};
            3'd2: r = {1'b0, a ^ b};
            3'd3: r = {1'b0, ~(a | b)};
            3'd4: r = {1'b0, a} + {1'b0, b};
            3'd5: r = {1'b0, a} - {1'b0, b};
            3'd6: r = {32'd0, (a < b)};
            default: r = {1'b0, b << a};
        endcase
        return r;
    endfunction

    // Behavioural ALU; force_ovf raises the flag for every op.
    always_comb alu_r = ref_alu(alu_op, alu_a, alu_b);
    assign alu_f    = alu_r[31:0];
    assign alu_ovf  = alu_r[32] | force_ovf;
    assign alu_zero = (alu_r[31:0] == 32'd0);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor and acceptance tap, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_last = '0;
        end else begin
            if (res_valid && res_ready) begin
                hs_q.push_back(cyc);
                got_q.push_back(res_f);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL result_unexpected: got f=%h ovf=%b zero=%b, none expected",
                             res_f, res_ovf, res_zero);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("result", 64'({res_zero, res_ovf, res_f}), 64'(mon_e));
                end
            end
            if (cmd_valid && cmd_ready) begin
`ifdef ALU_CTRL_CHAIN_EN
                tap_a = cmd_chain ? model_last : cmd_a;
`else
                tap_a = cmd_a;
`endif
                tap_r   = ref_alu(cmd_op, tap_a, cmd_b);
                tap_ovf = ((cmd_op == 3'd4) || (cmd_op == 3'd5)) ? (tap_r[32] | force_ovf) : 1'b0;
                exp_q.push_back({(tap_r[31:0] == 32'd0), tap_ovf, tap_r[31:0]});
                model_last = tap_r[31:0];
            end
        end
    end

    // Present a command and hold it until accepted; returns just after that edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic chain, output bit ok);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && !res_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    task automatic wait_hs(input int n, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (hs_q.size() >= n) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit got6;
        int base;

        vectors = 0; miscompares = 0; cyc = 0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_chain = 1'b0; res_ready = 1'b1; force_ovf = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("reset_outputs", 64'({res_valid, res_f, res_ovf, res_zero, busy, cmd_ready}), 64'(0));
        chk("reset_operands", 64'({alu_a, alu_op}), 64'(0));
        rst = 1'b0; #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;

        // ADD with carry out: latency and flags.
        send(32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, ok);
        chk("add_accept", 64'(ok), 64'(1));
        chk("add_valid_e0", 64'(res_valid), 64'(0));
        @(posedge clk); #1;
        chk("add_valid_e1", 64'(res_valid), 64'(0));
        chk("add_issue", 64'({alu_op, alu_a}), 64'({3'b100, 32'hFFFF_FFFF}));
        @(posedge clk); #1;
        chk("add_valid_e2", 64'(res_valid), 64'(1));
        chk("add_result", 64'({res_zero, res_ovf, res_f}), 64'({1'b1, 1'b1, 32'd0}));
        wait_idle("add_idle");

        // AND with the ALU raising a spurious overflow.
        force_ovf = 1'b1;
        send(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 1'b0, ok);
        chk("and_accept", 64'(ok), 64'(1));
        repeat (2) @(posedge clk); #1;
        chk("and_result", 64'({res_valid, res_zero, res_ovf, res_f}),
            64'({1'b1, 1'b0, 1'b0, 32'hF000_F000}));
        wait_idle("and_idle");
        force_ovf = 1'b0;

        // Backpressure: five commands absorbed, the sixth blocked.
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(32'd10 + 32'(k), 32'd7, 3'b100, 1'b0, ok);
            chk("stall_accept", 64'(ok), 64'(1));
        end
        cmd_a = 32'd99; cmd_b = 32'd1; cmd_op = 3'b001; cmd_chain = 1'b0; cmd_valid = 1'b1;
        got6 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (cmd_ready) got6 = 1'b1;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("stall_sixth_blocked", 64'(got6), 64'(0));
        chk("stall_ready_low", 64'(cmd_ready), 64'(0));
        base = hs_q.size();
        res_ready = 1'b1;
        wait_hs(base + 5, "stall_five_results");
        if (hs_q.size() >= base + 5) begin
            for (int k = 1; k < 5; k++)
                chk("stall_spacing", 64'(hs_q[base + k] - hs_q[base + k - 1]), 64'(2));
            for (int k = 0; k < 5; k++)
                chk("stall_order", 64'(got_q[base + k]), 64'(32'd17 + 32'(k)));
        end
        wait_idle("stall_idle");

        // Chained subtract.
        base = hs_q.size();
        send(32'd5, 32'd3, 3'b100, 1'b0, ok);
        send(32'd100, 32'd2, 3'b101, 1'b1, ok);
        wait_hs(base + 2, "chain_results");
        if (hs_q.size() >= base + 2) begin
            chk("chain_first", 64'(got_q[base]), 64'(8));
`ifdef ALU_CTRL_CHAIN_EN
            chk("chain_second", 64'(got_q[base + 1]), 64'(6));
`else
            chk("chain_second", 64'(got_q[base + 1]), 64'(98));
`endif
        end
        wait_idle("chain_idle");

        // Reset while a result is held and three commands are queued.
        res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(32'd1, 32'd2 + 32'(k), 3'b001, 1'b0, ok);
            chk("rst_fill_accept", 64'(ok), 64'(1));
        end
        chk("rst_pre_done", 64'({res_valid, busy}), 64'(2'b11));
        rst = 1'b1; #1;
        chk("rst_async_outputs",
            64'({res_valid, res_f, res_ovf, res_zero, busy, cmd_ready, alu_op}), 64'(0));
        chk("rst_async_operands", 64'({alu_a, alu_b}), 64'(0));
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("rst_release", 64'({cmd_ready, busy, res_valid}), 64'(3'b100));
        res_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("rst_no_stale", 64'({busy, res_valid}), 64'(0));

        // Randomized traffic, with and without a spurious ALU overflow.
        for (int phase = 0; phase < 2; phase++) begin
            force_ovf = (phase == 1);
            for (int i = 0; i < 300; i++) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_a     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                cmd_b     = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                cmd_chain = 1'($urandom_range(0, 1));
                res_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            cmd_valid = 1'b0;
            res_ready = 1'b1;
            wait_idle("random_drain");
            chk("random_scoreboard_empty", 64'(exp_q.size()), 64'(0));
        end
        force_ovf = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
